// File: rtl/pe_pkg.sv
// Shared widths, message-type codes and message field offsets for the PE mesh.
// Used by the PE RTL and by its benches so both agree on message layout.
package pe_pkg;

    localparam int DEF_CORDINATE_WIDTH   = 4;
    localparam int DEF_COST_WIDTH        = 8;
    localparam int DEF_TIMESTAMP_WIDTH   = 8;
    localparam int DEF_MAX_HOP_WIDTH     = 4;
    localparam int DEF_MSG_TYPE_WIDTH    = 3;
    localparam int DEF_MAX_HOPS          = 4;
    localparam int DEF_MSG_WIDTH         = 6*DEF_CORDINATE_WIDTH + DEF_TIMESTAMP_WIDTH
                                         + DEF_COST_WIDTH + DEF_MAX_HOP_WIDTH + DEF_MSG_TYPE_WIDTH;
    localparam int DEF_MATCH_VALUE_WIDTH = 2*DEF_CORDINATE_WIDTH + 2;

    // Field offsets (LSB position) for the default widths, LSB field first.
    localparam int OFS_MSG_TYPE     = 0;
    localparam int OFS_MAX_HOPS     = OFS_MSG_TYPE + DEF_MSG_TYPE_WIDTH;
    localparam int OFS_COST         = OFS_MAX_HOPS + DEF_MAX_HOP_WIDTH;
    localparam int OFS_TIMESTAMP    = OFS_COST + DEF_COST_WIDTH;
    localparam int OFS_BROKER_COL   = OFS_TIMESTAMP + DEF_TIMESTAMP_WIDTH;
    localparam int OFS_BROKER_ROW   = OFS_BROKER_COL + DEF_CORDINATE_WIDTH;
    localparam int OFS_SOURCE_COL   = OFS_BROKER_ROW + DEF_CORDINATE_WIDTH;
    localparam int OFS_SOURCE_ROW   = OFS_SOURCE_COL + DEF_CORDINATE_WIDTH;
    localparam int OFS_RECEIVER_COL = OFS_SOURCE_ROW + DEF_CORDINATE_WIDTH;
    localparam int OFS_RECEIVER_ROW = OFS_RECEIVER_COL + DEF_CORDINATE_WIDTH;

    typedef enum logic [2:0] {
        MSG_NONE  = 3'd0,
        MSG_OFFER = 3'd1
    } msg_type_e;

    // Direction index doubles as mailbox service priority (lowest first).
    localparam int DIR_N = 0;
    localparam int DIR_E = 1;
    localparam int DIR_W = 2;
    localparam int DIR_S = 3;

endpackage

// File: rtl/pe_slot.sv
// One-entry valid-ready buffer used for both mailboxes and outqueues.
// A load in the same cycle as a clear wins, so a drained slot can be refilled at once.
module pe_slot #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             clear,
    output logic             full,
    output logic [WIDTH-1:0] value
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            full  <= 1'b0;
            value <= '0;
        end else if (load) begin
            full  <= 1'b1;
            value <= load_value;
        end else if (clear) begin
            full  <= 1'b0;
            value <= '0;
        end
    end

endmodule

// File: rtl/pe.sv
// Mesh processing element: issues offers from defects, relays offers through
// non-defects, and at stop_offer reports the best partner or the boundary.
module pe
    import pe_pkg::*;
#(
    parameter int CORDINATE_WIDTH   = DEF_CORDINATE_WIDTH,
    parameter int COST_WIDTH        = DEF_COST_WIDTH,
    parameter int TIMESTAMP_WIDTH   = DEF_TIMESTAMP_WIDTH,
    parameter int MAX_HOP_WIDTH     = DEF_MAX_HOP_WIDTH,
    parameter int MSG_TYPE_WIDTH    = DEF_MSG_TYPE_WIDTH,
    parameter int MSG_WIDTH         = 6*CORDINATE_WIDTH + TIMESTAMP_WIDTH + COST_WIDTH
                                    + MAX_HOP_WIDTH + MSG_TYPE_WIDTH,
    parameter int MATCH_VALUE_WIDTH = 2*CORDINATE_WIDTH + 2,
    parameter int MAX_HOPS          = DEF_MAX_HOPS
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          measurement_value_in,
    input  logic                          measurement_valid_in,
    input  logic                          start_offer,
    input  logic                          stop_offer,
    input  logic [CORDINATE_WIDTH-1:0]    ROW_ID,
    input  logic [CORDINATE_WIDTH-1:0]    COL_ID,
    input  logic signed [COST_WIDTH-1:0]  BOUNDARY_COST,
    input  logic [MSG_WIDTH-1:0]          mailbox_north_value_in,
    input  logic                          mailbox_north_valid_in,
    output logic                          mailbox_north_ready_out,
    input  logic [MSG_WIDTH-1:0]          mailbox_east_value_in,
    input  logic                          mailbox_east_valid_in,
    output logic                          mailbox_east_ready_out,
    input  logic [MSG_WIDTH-1:0]          mailbox_west_value_in,
    input  logic                          mailbox_west_valid_in,
    output logic                          mailbox_west_ready_out,
    input  logic [MSG_WIDTH-1:0]          mailbox_south_value_in,
    input  logic                          mailbox_south_valid_in,
    output logic                          mailbox_south_ready_out,
    output logic [MSG_WIDTH-1:0]          outqueue_north_value_out,
    output logic                          outqueue_north_valid_out,
    input  logic                          outqueue_north_ready_in,
    output logic [MSG_WIDTH-1:0]          outqueue_east_value_out,
    output logic                          outqueue_east_valid_out,
    input  logic                          outqueue_east_ready_in,
    output logic [MSG_WIDTH-1:0]          outqueue_west_value_out,
    output logic                          outqueue_west_valid_out,
    input  logic                          outqueue_west_ready_in,
    output logic [MSG_WIDTH-1:0]          outqueue_south_value_out,
    output logic                          outqueue_south_valid_out,
    input  logic                          outqueue_south_ready_in,
    output logic [MATCH_VALUE_WIDTH-1:0]  match_value_out
);

    typedef struct packed {
        logic [CORDINATE_WIDTH-1:0]   rx_row;
        logic [CORDINATE_WIDTH-1:0]   rx_col;
        logic [CORDINATE_WIDTH-1:0]   src_row;
        logic [CORDINATE_WIDTH-1:0]   src_col;
        logic [CORDINATE_WIDTH-1:0]   brk_row;
        logic [CORDINATE_WIDTH-1:0]   brk_col;
        logic [TIMESTAMP_WIDTH-1:0]   ts;
        logic signed [COST_WIDTH-1:0] cost;
        logic [MAX_HOP_WIDTH-1:0]     hops;
        logic [MSG_TYPE_WIDTH-1:0]    mtype;
    } msg_t;

    localparam logic signed [COST_WIDTH-1:0] COST_MAX = {1'b0, {(COST_WIDTH-1){1'b1}}};

    logic [TIMESTAMP_WIDTH-1:0]   ts_cnt;
    logic                         is_defect;
    logic                         best_valid;
    logic signed [COST_WIDTH-1:0] best_cost;
    logic [CORDINATE_WIDTH-1:0]   best_row, best_col;
    logic [3:0]                   pending, issue;

    logic [3:0]                   mb_valid_in, mb_full, mb_consume;
    logic [MSG_WIDTH-1:0]         mb_in   [4];
    logic [MSG_WIDTH-1:0]         mb_data [4];
    logic [3:0]                   oq_ready, oq_full, oq_free, oq_load;
    logic [MSG_WIDTH-1:0]         oq_next [4];
    logic [MSG_WIDTH-1:0]         oq_data [4];
    logic [CORDINATE_WIDTH-1:0]   nbr_row [4];
    logic [CORDINATE_WIDTH-1:0]   nbr_col [4];

    logic       sel_valid, own_src, live_offer, better, accept, relay_want, relay_ok, relay_fire;
    logic [1:0] sel;
    msg_t       cur, relay_msg, fwd, offer;

    assign mb_valid_in = {mailbox_south_valid_in, mailbox_west_valid_in,
                          mailbox_east_valid_in, mailbox_north_valid_in};
    assign oq_ready    = {outqueue_south_ready_in, outqueue_west_ready_in,
                          outqueue_east_ready_in, outqueue_north_ready_in};
    assign mb_in[DIR_N] = mailbox_north_value_in;
    assign mb_in[DIR_E] = mailbox_east_value_in;
    assign mb_in[DIR_W] = mailbox_west_value_in;
    assign mb_in[DIR_S] = mailbox_south_value_in;

    assign mailbox_north_ready_out  = ~mb_full[DIR_N];
    assign mailbox_east_ready_out   = ~mb_full[DIR_E];
    assign mailbox_west_ready_out   = ~mb_full[DIR_W];
    assign mailbox_south_ready_out  = ~mb_full[DIR_S];
    assign outqueue_north_valid_out = oq_full[DIR_N];
    assign outqueue_east_valid_out  = oq_full[DIR_E];
    assign outqueue_west_valid_out  = oq_full[DIR_W];
    assign outqueue_south_valid_out = oq_full[DIR_S];
    assign outqueue_north_value_out = oq_data[DIR_N];
    assign outqueue_east_value_out  = oq_data[DIR_E];
    assign outqueue_west_value_out  = oq_data[DIR_W];
    assign outqueue_south_value_out = oq_data[DIR_S];

    for (genvar d = 0; d < 4; d++) begin : g_dir
        pe_slot #(.WIDTH(MSG_WIDTH)) u_mailbox (
            .clk        (clk),
            .reset      (reset),
            .load       (mb_valid_in[d] & ~mb_full[d]),
            .load_value (mb_in[d]),
            .clear      (mb_consume[d]),
            .full       (mb_full[d]),
            .value      (mb_data[d])
        );
        pe_slot #(.WIDTH(MSG_WIDTH)) u_outqueue (
            .clk        (clk),
            .reset      (reset),
            .load       (oq_load[d]),
            .load_value (oq_next[d]),
            .clear      (oq_full[d] & oq_ready[d]),
            .full       (oq_full[d]),
            .value      (oq_data[d])
        );
    end

    // Neighbour coordinates wrap around the mesh edge.
    always_comb begin
        nbr_row[DIR_N] = ROW_ID - CORDINATE_WIDTH'(1);
        nbr_col[DIR_N] = COL_ID;
        nbr_row[DIR_S] = ROW_ID + CORDINATE_WIDTH'(1);
        nbr_col[DIR_S] = COL_ID;
        nbr_row[DIR_E] = ROW_ID;
        nbr_col[DIR_E] = COL_ID + CORDINATE_WIDTH'(1);
        nbr_row[DIR_W] = ROW_ID;
        nbr_col[DIR_W] = COL_ID - CORDINATE_WIDTH'(1);
    end

    always_comb begin
        sel_valid = 1'b0;
        sel       = 2'd0;
        for (int d = 3; d >= 0; d--) begin
            if (mb_full[d]) begin
                sel_valid = 1'b1;
                sel       = 2'(d);
            end
        end
        cur        = mb_data[sel];
        own_src    = (cur.src_row == ROW_ID) && (cur.src_col == COL_ID);
        live_offer = sel_valid && (cur.mtype == MSG_TYPE_WIDTH'(MSG_OFFER)) && !own_src;
        better     = !best_valid || (cur.cost < best_cost) ||
                     ((cur.cost == best_cost) && ({cur.src_row, cur.src_col} < {best_row, best_col}));
        accept     = live_offer && is_defect && better;
        relay_want = live_offer && !is_defect && (cur.hops > MAX_HOP_WIDTH'(1));

        relay_msg      = cur;
        relay_msg.cost = (cur.cost == COST_MAX) ? cur.cost : cur.cost + COST_WIDTH'(1);
        relay_msg.hops = cur.hops - MAX_HOP_WIDTH'(1);

        // A pending offer claims its outqueue this cycle, so a relay must wait for it.
        relay_ok = 1'b1;
        for (int d = 0; d < 4; d++) begin
            oq_free[d] = !oq_full[d] || oq_ready[d];
            issue[d]   = pending[d] && oq_free[d];
            if ((2'(d) != sel) && (!oq_free[d] || pending[d])) relay_ok = 1'b0;
        end
        relay_fire = relay_want && relay_ok;

        mb_consume = 4'b0000;
        if (sel_valid && (!relay_want || relay_ok)) mb_consume[sel] = 1'b1;

        offer = '0;
        fwd   = '0;
        for (int d = 0; d < 4; d++) begin
            oq_load[d] = 1'b0;
            oq_next[d] = '0;
            if (issue[d]) begin
                offer.rx_row  = nbr_row[d];
                offer.rx_col  = nbr_col[d];
                offer.src_row = ROW_ID;
                offer.src_col = COL_ID;
                offer.brk_row = ROW_ID;
                offer.brk_col = COL_ID;
                offer.ts      = ts_cnt;
                offer.cost    = COST_WIDTH'(1);
                offer.hops    = MAX_HOP_WIDTH'(MAX_HOPS);
                offer.mtype   = MSG_TYPE_WIDTH'(MSG_OFFER);
                oq_load[d]    = 1'b1;
                oq_next[d]    = offer;
            end else if (relay_fire && (2'(d) != sel)) begin
                fwd        = relay_msg;
                fwd.rx_row = nbr_row[d];
                fwd.rx_col = nbr_col[d];
                oq_load[d] = 1'b1;
                oq_next[d] = fwd;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ts_cnt          <= '0;
            pending         <= 4'b0000;
            is_defect       <= 1'b0;
            best_valid      <= 1'b0;
            best_cost       <= '0;
            best_row        <= '0;
            best_col        <= '0;
            match_value_out <= '0;
        end else begin
            ts_cnt  <= ts_cnt + TIMESTAMP_WIDTH'(1);
            pending <= (pending & ~issue) |
                       ((start_offer && !stop_offer && is_defect) ? 4'b1111 : 4'b0000);
            if (accept) begin
                best_valid <= 1'b1;
                best_cost  <= cur.cost;
                best_row   <= cur.src_row;
                best_col   <= cur.src_col;
            end
            if (stop_offer && is_defect) begin
                if (best_valid && (best_cost < BOUNDARY_COST))
                    match_value_out <= {1'b1, 1'b0, best_row, best_col};
                else
                    match_value_out <= {1'b1, 1'b1, ROW_ID, COL_ID};
            end
            // A new measurement starts a fresh round and overrides everything above.
            if (measurement_valid_in) begin
                is_defect       <= measurement_value_in;
                best_valid      <= 1'b0;
                best_cost       <= '0;
                best_row        <= '0;
                best_col        <= '0;
                match_value_out <= '0;
            end
        end
    end

endmodule

// File: tb/tb_pe.sv
// Self-checking bench for pe: expected outbound messages are queued per direction
// as stimulus is driven and compared when the DUT hands them off.
module tb_pe;
    import pe_pkg::*;

    localparam int CW = DEF_CORDINATE_WIDTH;
    localparam int MW = DEF_MSG_WIDTH;
    localparam int VW = DEF_MATCH_VALUE_WIDTH;

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic                 meas_val = 1'b0, meas_vld = 1'b0;
    logic                 start_offer = 1'b0, stop_offer = 1'b0;
    logic [CW-1:0]        row_id = 4'd4, col_id = 4'd2;
    logic signed [7:0]    bcost = 8'sd6;
    logic [MW-1:0]        mb_val [4];
    logic [3:0]           mb_vld = 4'b0000;
    logic [3:0]           mb_rdy;
    logic [MW-1:0]        oq_val [4];
    logic [3:0]           oq_vld;
    logic [3:0]           oq_rdy = 4'b1111;
    logic [VW-1:0]        match;
    logic [7:0]           tb_ts;

    int checks = 0;
    int errors = 0;
    logic [MW-1:0] exp_q [4][$];

    always #5 clk = ~clk;

    pe dut (
        .clk                      (clk),
        .reset                    (reset),
        .measurement_value_in     (meas_val),
        .measurement_valid_in     (meas_vld),
        .start_offer              (start_offer),
        .stop_offer               (stop_offer),
        .ROW_ID                   (row_id),
        .COL_ID                   (col_id),
        .BOUNDARY_COST            (bcost),
        .mailbox_north_value_in   (mb_val[DIR_N]),
        .mailbox_north_valid_in   (mb_vld[DIR_N]),
        .mailbox_north_ready_out  (mb_rdy[DIR_N]),
        .mailbox_east_value_in    (mb_val[DIR_E]),
        .mailbox_east_valid_in    (mb_vld[DIR_E]),
        .mailbox_east_ready_out   (mb_rdy[DIR_E]),
        .mailbox_west_value_in    (mb_val[DIR_W]),
        .mailbox_west_valid_in    (mb_vld[DIR_W]),
        .mailbox_west_ready_out   (mb_rdy[DIR_W]),
        .mailbox_south_value_in   (mb_val[DIR_S]),
        .mailbox_south_valid_in   (mb_vld[DIR_S]),
        .mailbox_south_ready_out  (mb_rdy[DIR_S]),
        .outqueue_north_value_out (oq_val[DIR_N]),
        .outqueue_north_valid_out (oq_vld[DIR_N]),
        .outqueue_north_ready_in  (oq_rdy[DIR_N]),
        .outqueue_east_value_out  (oq_val[DIR_E]),
        .outqueue_east_valid_out  (oq_vld[DIR_E]),
        .outqueue_east_ready_in   (oq_rdy[DIR_E]),
        .outqueue_west_value_out  (oq_val[DIR_W]),
        .outqueue_west_valid_out  (oq_vld[DIR_W]),
        .outqueue_west_ready_in   (oq_rdy[DIR_W]),
        .outqueue_south_value_out (oq_val[DIR_S]),
        .outqueue_south_valid_out (oq_vld[DIR_S]),
        .outqueue_south_ready_in  (oq_rdy[DIR_S]),
        .match_value_out          (match)
    );

    // Reference timestamp: reset to 0, +1 per clock.
    always @(posedge clk or negedge reset) begin
        if (!reset) tb_ts <= 8'd0;
        else        tb_ts <= tb_ts + 8'd1;
    end

    function automatic string dname(input int d);
        case (d)
            DIR_N:   return "north";
            DIR_E:   return "east";
            DIR_W:   return "west";
            default: return "south";
        endcase
    endfunction

    function automatic logic [MW-1:0] mk(input int rr, rc, sr, sc, br, bc, ts, cost, hops, mt);
        logic [MW-1:0] m;
        m = {CW'(rr), CW'(rc), CW'(sr), CW'(sc), CW'(br), CW'(bc),
             DEF_TIMESTAMP_WIDTH'(ts), DEF_COST_WIDTH'(cost),
             DEF_MAX_HOP_WIDTH'(hops), DEF_MSG_TYPE_WIDTH'(mt)};
        return m;
    endfunction

    // Scoreboard: a handoff happens at the next rising edge when valid and ready are both high.
    always @(negedge clk) begin
        if (reset) begin
            for (int d = 0; d < 4; d++) begin
                if (oq_vld[d] && oq_rdy[d]) begin
                    checks++;
                    if (exp_q[d].size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_%s got %h required none", dname(d), oq_val[d]);
                    end else begin
                        logic [MW-1:0] e;
                        e = exp_q[d].pop_front();
                        if (oq_val[d] !== e) begin
                            errors++;
                            $display("FAIL msg_%s got %h required %h", dname(d), oq_val[d], e);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout_global got running required finished");
        $fatal(1, "bench timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic measure(input logic v);
        meas_vld = 1'b1;
        meas_val = v;
        tick();
        meas_vld = 1'b0;
    endtask

    task automatic send(input int d, input logic [MW-1:0] m);
        mb_val[d] = m;
        mb_vld[d] = 1'b1;
        tick();
        mb_vld[d] = 1'b0;
        tick();
    endtask

    task automatic stop_pulse();
        stop_offer = 1'b1;
        tick();
        stop_offer = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        checks++; if (mb_rdy !== 4'b1111) begin errors++; $display("FAIL reset_ready got %b required 1111", mb_rdy); end
        checks++; if (oq_vld !== 4'b0000) begin errors++; $display("FAIL reset_valid got %b required 0000", oq_vld); end
        checks++; if (match !== '0) begin errors++; $display("FAIL reset_match got %h required 0", match); end
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (oq_val[d] !== '0) begin errors++; $display("FAIL reset_value_%s got %h required 0", dname(d), oq_val[d]); end
        end
        @(negedge clk);
        reset = 1'b1;
        tick();
        checks++; if (oq_vld !== 4'b0000) begin errors++; $display("FAIL idle_valid got %b required 0000", oq_vld); end
    endtask

    task automatic test_offer_issue();
        int ts;
        measure(1'b1);
        start_offer = 1'b1;
        tick();
        start_offer = 1'b0;
        ts = int'(tb_ts);
        exp_q[DIR_N].push_back(mk(3, 2, 4, 2, 4, 2, ts, 1, 4, 1));
        exp_q[DIR_E].push_back(mk(4, 3, 4, 2, 4, 2, ts, 1, 4, 1));
        exp_q[DIR_W].push_back(mk(4, 1, 4, 2, 4, 2, ts, 1, 4, 1));
        exp_q[DIR_S].push_back(mk(5, 2, 4, 2, 4, 2, ts, 1, 4, 1));
        repeat (6) tick();
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (exp_q[d].size() != 0) begin errors++; $display("FAIL offer_drain_%s got %0d left required 0", dname(d), exp_q[d].size()); end
        end
    endtask

    task automatic test_relay();
        measure(1'b0);
        exp_q[DIR_N].push_back(mk(3, 2, 4, 5, 4, 5, 9, 3, 2, 1));
        exp_q[DIR_W].push_back(mk(4, 1, 4, 5, 4, 5, 9, 3, 2, 1));
        exp_q[DIR_S].push_back(mk(5, 2, 4, 5, 4, 5, 9, 3, 2, 1));
        send(DIR_E, mk(4, 2, 4, 5, 4, 5, 9, 2, 3, 1));
        // Cost saturates at +127 rather than wrapping negative.
        exp_q[DIR_E].push_back(mk(4, 3, 1, 1, 1, 1, 0, 127, 1, 1));
        exp_q[DIR_N].push_back(mk(3, 2, 1, 1, 1, 1, 0, 127, 1, 1));
        exp_q[DIR_S].push_back(mk(5, 2, 1, 1, 1, 1, 0, 127, 1, 1));
        send(DIR_W, mk(4, 2, 1, 1, 1, 1, 0, 127, 2, 1));
        repeat (6) tick();
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (exp_q[d].size() != 0) begin errors++; $display("FAIL relay_drain_%s got %0d left required 0", dname(d), exp_q[d].size()); end
        end
    endtask

    task automatic test_best_offer();
        measure(1'b1);
        send(DIR_N, mk(4, 2, 1, 1, 1, 1, 0, 3, 4, 1));
        send(DIR_N, mk(4, 2, 7, 7, 7, 7, 0, 2, 4, 1));
        checks++; if (match !== '0) begin errors++; $display("FAIL best_prestop got %h required 0", match); end
        stop_pulse();
        checks++; if (match !== {2'b10, 4'd7, 4'd7}) begin errors++; $display("FAIL best_lowest got %h required %h", match, {2'b10, 4'd7, 4'd7}); end
        measure(1'b1);
        checks++; if (match !== '0) begin errors++; $display("FAIL measure_clears got %h required 0", match); end
        send(DIR_S, mk(4, 2, 7, 7, 7, 7, 0, 2, 4, 1));
        send(DIR_E, mk(4, 2, 3, 3, 3, 3, 0, 2, 4, 1));
        send(DIR_W, mk(4, 2, 5, 0, 5, 0, 0, 2, 4, 1));
        stop_pulse();
        checks++; if (match !== {2'b10, 4'd3, 4'd3}) begin errors++; $display("FAIL best_tie got %h required %h", match, {2'b10, 4'd3, 4'd3}); end
    endtask

    task automatic test_boundary();
        measure(1'b1);
        send(DIR_N, mk(4, 2, 2, 2, 2, 2, 0, 6, 4, 1));
        stop_pulse();
        checks++; if (match !== {2'b11, 4'd4, 4'd2}) begin errors++; $display("FAIL boundary_equal got %h required %h", match, {2'b11, 4'd4, 4'd2}); end
        measure(1'b1);
        send(DIR_N, mk(4, 2, 2, 2, 2, 2, 0, 5, 4, 1));
        stop_pulse();
        checks++; if (match !== {2'b10, 4'd2, 4'd2}) begin errors++; $display("FAIL boundary_below got %h required %h", match, {2'b10, 4'd2, 4'd2}); end
        measure(1'b1);
        stop_pulse();
        checks++; if (match !== {2'b11, 4'd4, 4'd2}) begin errors++; $display("FAIL boundary_nobest got %h required %h", match, {2'b11, 4'd4, 4'd2}); end
        measure(1'b0);
        stop_pulse();
        checks++; if (match !== '0) begin errors++; $display("FAIL nondefect_stop got %h required 0", match); end
    endtask

    task automatic test_drops();
        measure(1'b0);
        send(DIR_N, mk(4, 2, 0, 0, 0, 0, 0, 2, 1, 1));
        send(DIR_E, mk(4, 2, 0, 0, 0, 0, 0, 2, 3, 2));
        send(DIR_W, mk(4, 2, 0, 0, 0, 0, 0, 2, 3, 0));
        send(DIR_S, mk(4, 2, 4, 2, 4, 2, 0, 2, 3, 1));
        checks++; if (mb_rdy !== 4'b1111) begin errors++; $display("FAIL drop_consumed got %b required 1111", mb_rdy); end
        measure(1'b1);
        send(DIR_N, mk(4, 2, 4, 2, 4, 2, 0, 0, 3, 1));
        stop_pulse();
        checks++; if (match !== {2'b11, 4'd4, 4'd2}) begin errors++; $display("FAIL drop_self got %h required %h", match, {2'b11, 4'd4, 4'd2}); end
        repeat (4) tick();
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (exp_q[d].size() != 0) begin errors++; $display("FAIL drop_drain_%s got %0d left required 0", dname(d), exp_q[d].size()); end
        end
    endtask

    task automatic test_stall();
        bit released;
        measure(1'b0);
        oq_rdy[DIR_W] = 1'b0;
        for (int k = 1; k <= 2; k++) begin
            exp_q[DIR_N].push_back(mk(3, 2, 4, 4 + k, 4, 4 + k, k, 3, 2, 1));
            exp_q[DIR_W].push_back(mk(4, 1, 4, 4 + k, 4, 4 + k, k, 3, 2, 1));
            exp_q[DIR_S].push_back(mk(5, 2, 4, 4 + k, 4, 4 + k, k, 3, 2, 1));
        end
        send(DIR_E, mk(4, 2, 4, 5, 4, 5, 1, 2, 3, 1));
        send(DIR_E, mk(4, 2, 4, 6, 4, 6, 2, 2, 3, 1));
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (mb_rdy[DIR_E] !== 1'b0) begin errors++; $display("FAIL stall_ready cycle %0d got %b required 0", i, mb_rdy[DIR_E]); end
            tick();
        end
        checks++; if (oq_vld[DIR_W] !== 1'b1) begin errors++; $display("FAIL stall_west_held got %b required 1", oq_vld[DIR_W]); end
        oq_rdy[DIR_W] = 1'b1;
        released = 1'b0;
        for (int i = 0; i < 10 && !released; i++) begin
            tick();
            if (mb_rdy[DIR_E] === 1'b1) released = 1'b1;
        end
        checks++; if (!released) begin errors++; $display("FAIL stall_release got ready 0 required 1 within 10 cycles"); end
        repeat (6) tick();
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (exp_q[d].size() != 0) begin errors++; $display("FAIL stall_drain_%s got %0d left required 0", dname(d), exp_q[d].size()); end
        end
    endtask

    task automatic test_simultaneous();
        measure(1'b1);
        send(DIR_N, mk(4, 2, 1, 1, 1, 1, 0, 3, 4, 1));
        start_offer = 1'b1;
        stop_offer  = 1'b1;
        tick();
        start_offer = 1'b0;
        stop_offer  = 1'b0;
        checks++; if (match !== {2'b10, 4'd1, 4'd1}) begin errors++; $display("FAIL simul_match got %h required %h", match, {2'b10, 4'd1, 4'd1}); end
        repeat (4) tick();
        checks++; if (oq_vld !== 4'b0000) begin errors++; $display("FAIL simul_no_offer got %b required 0000", oq_vld); end
    endtask

    task automatic test_reset_midop();
        oq_rdy = 4'b0000;
        measure(1'b1);
        send(DIR_N, mk(4, 2, 1, 1, 1, 1, 0, 1, 4, 1));
        stop_pulse();
        start_offer = 1'b1;
        tick();
        start_offer = 1'b0;
        send(DIR_S, mk(4, 2, 0, 0, 0, 0, 0, 2, 3, 1));
        send(DIR_N, mk(4, 2, 0, 0, 0, 0, 0, 2, 3, 1));
        checks++; if (oq_vld !== 4'b1111) begin errors++; $display("FAIL midop_full got %b required 1111", oq_vld); end
        checks++; if (match === '0) begin errors++; $display("FAIL midop_match_set got %h required nonzero", match); end
        #3;
        reset = 1'b0;
        #2;
        checks++; if (oq_vld !== 4'b0000) begin errors++; $display("FAIL midop_valid got %b required 0000", oq_vld); end
        checks++; if (match !== '0) begin errors++; $display("FAIL midop_match got %h required 0", match); end
        checks++; if (mb_rdy !== 4'b1111) begin errors++; $display("FAIL midop_ready got %b required 1111", mb_rdy); end
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (oq_val[d] !== '0) begin errors++; $display("FAIL midop_value_%s got %h required 0", dname(d), oq_val[d]); end
        end
        tick();
        reset  = 1'b1;
        oq_rdy = 4'b1111;
        repeat (6) tick();
        checks++; if (oq_vld !== 4'b0000) begin errors++; $display("FAIL midop_after got %b required 0000", oq_vld); end
    endtask

    initial begin
        for (int d = 0; d < 4; d++) mb_val[d] = '0;
        test_reset();
        test_offer_issue();
        test_relay();
        test_best_offer();
        test_boundary();
        test_drops();
        test_stall();
        test_simultaneous();
        test_reset_midop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pe.md
PE -- requirements
Module: pe

Interface
REQ-001 Parameter CORDINATE_WIDTH, 4, bits per row or column coordinate.
REQ-002 Parameter COST_WIDTH, 8, signed cost field width.
REQ-003 Parameter TIMESTAMP_WIDTH, 8, timestamp field width.
REQ-004 Parameter MAX_HOP_WIDTH, 4, hop-budget field width.
REQ-005 Parameter MSG_TYPE_WIDTH, 3, message-type field width.
REQ-006 Parameter MSG_WIDTH, 6*CORDINATE_WIDTH+TIMESTAMP_WIDTH+COST_WIDTH+MAX_HOP_WIDTH+MSG_TYPE_WIDTH, message width.
REQ-007 Parameter MATCH_VALUE_WIDTH, 2*CORDINATE_WIDTH+2, match result width.
REQ-008 Parameter MAX_HOPS, 4, hop budget stamped on new offers.
REQ-009 Clock and reset SHALL be: one clock; reset is asynchronous and active-low; ports clk and reset.
REQ-010 clk  in  1  rising-edge clock.
REQ-011 reset  in  1  asynchronous, active-low reset.
REQ-012 measurement_value_in / measurement_valid_in  in  1/1  syndrome bit and its strobe.
REQ-013 start_offer / stop_offer  in  1/1  single-cycle phase pulses.
REQ-014 ROW_ID, COL_ID  in  CORDINATE_WIDTH  own coordinates; BOUNDARY_COST  in  COST_WIDTH  cost to boundary.
REQ-015 mailbox_{north,east,west,south}_value_in/valid_in/ready_out  in/in/out  MSG_WIDTH/1/1  inbound valid-ready links.
REQ-016 outqueue_{north,east,west,south}_value_out/valid_out/ready_in  out/out/in  MSG_WIDTH/1/1  outbound valid-ready links.
REQ-017 match_value_out  out  MATCH_VALUE_WIDTH  {matched, boundary, partner_row, partner_col}.

Function
REQ-018 Message fields, MSB to LSB: receiver_row, receiver_col, source_row, source_col, broker_row, broker_col, timestamp, cost (signed), max_hops, msg_type.
REQ-019 Types: 0 NONE, 1 OFFER; other codes are received and dropped.
REQ-020 Each mailbox is a one-entry register: ready_out = empty; load on valid&&ready; freed when its message is consumed.
REQ-021 Each outqueue is a one-entry register: valid_out = full; cleared on ready_in; reload allowed in the same cycle as clear.
REQ-022 measurement_valid_in captures is_defect <= measurement_value_in, clears best offer and match_value_out to 0.
REQ-023 Free-running timestamp counter, reset 0, increments each cycle, wraps modulo 2^TIMESTAMP_WIDTH.
REQ-024 start_offer with is_defect=1 sets a pending-offer flag per direction; each is issued when that outqueue is free: OFFER, receiver = neighbour (N row-1, S row+1, E col+1, W col-1, modulo 2^CORDINATE_WIDTH), source = broker = own, cost 1, timestamp = counter, max_hops = MAX_HOPS.
REQ-025 Pending offers have priority over relays for the same outqueue.
REQ-026 One mailbox message is consumed per cycle, fixed priority north, east, west, south.
REQ-027 OFFER with source = own coordinates: dropped.
REQ-028 OFFER at defect PE: recorded as best offer if no best exists or cost is lower; on equal cost, lower (source_row, source_col) wins; not relayed.
REQ-029 OFFER at non-defect PE with max_hops>1: relayed to the three directions other than arrival, receiver = that neighbour, cost+1 saturating at max positive, max_hops-1, other fields unchanged; consumed only when all three outqueues are free, else mailbox held (stall).
REQ-030 OFFER at non-defect PE with max_hops<=1: dropped.
REQ-031 stop_offer with is_defect=1: best exists and cost < BOUNDARY_COST -> match_value_out = {1,0,source_row,source_col}; else {1,1,ROW_ID,COL_ID}; non-defect PE keeps 0.
REQ-032 Simultaneous start_offer and stop_offer: stop_offer is evaluated against prior state and start_offer is ignored.

Reset
REQ-033 Reset SHALL clear all mailboxes and outqueues (ready_out=1, valid_out=0, value_out=0), pending flags, is_defect, best offer, timestamp counter, and set match_value_out=0.
REQ-034 Reset asserted mid-operation SHALL discard in-flight messages immediately.

Structure
REQ-035 Width parameters, message-type codes and field-offset constants SHALL live in a shared parameters include used by pe and benches.
REQ-036 The one-entry valid-ready buffer SHALL be a sub-module pe_slot, instantiated eight times.

Verification
REQ-037 ROW_ID=4, COL_ID=2, BOUNDARY_COST=6; measurement 1, start_offer -> east: type 1, dest 4,3, src 4,2, broker 4,2, cost 1, hops 4; north dest 3,2; south 5,2; west 4,1.
REQ-038 Non-defect; east mailbox OFFER src 4,5 cost 2 hops 3 -> north/south/west relays cost 3 hops 2; nothing east.
REQ-039 Defect; offers cost 3 from 1,1 then cost 2 from 7,7; stop_offer -> match_value_out = {1,0,7,7}.
REQ-040 Defect; best offer cost 6, BOUNDARY_COST=6; stop_offer -> {1,1,4,2}.
REQ-041 west outqueue ready_in=0 during relay -> mailbox ready_out stays 0 until released, no message lost or duplicated.
REQ-042 Reset asserted while outqueues full -> all valid_out=0, match_value_out=0 immediately.
